// File: rtl/burst_sram_pkg.sv
// rtl/burst_sram_pkg.sv - shared widths, depth and FSM state type for the burst SRAM master
package burst_sram_pkg;

  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    BURST,
    DRAIN,
    TURN
  } bsm_state_t;

  // True when a burst starting at addr with len beats would run past the top of the array.
  function automatic logic exceeds_depth(input logic [ADDR_W-1:0] addr,
                                         input logic [LEN_W-1:0]  len);
    return ({1'b0, addr} + {1'b0, len}) > 5'(DEPTH);
  endfunction

endpackage

// File: rtl/burst_wbuf.sv
// rtl/burst_wbuf.sv - 16x8 register-file staging buffer for write-burst payload
module burst_wbuf
  import burst_sram_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents are don't-care after reset; every entry is rewritten before it is read.
  logic [DATA_W-1:0] mem [DEPTH];

  // Capture one write beat per accepted wdata handshake.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/burst_sram_master.sv
// rtl/burst_sram_master.sv - burst SRAM initiator: request port, write staging, burst sequencing, read beat stream (optional BURST_SRAM_MASTER_BOUND_CHECK_EN)
module burst_sram_master
  import burst_sram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [LEN_W-1:0]  sram_burst_len,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  bsm_state_t        state;
  bsm_state_t        state_nxt;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [LEN_W-1:0]  lat_len;
  logic [LEN_W-1:0]  cnt;

  logic              accept;
  logic              wbeat;
  logic              last_beat;
  logic              reject;
  logic              issue;
  logic              pend_valid;
  logic              pend_last;
  logic              tap_valid;
  logic              tap_last;
  logic [DATA_W-1:0] buf_rd;

  assign req_ready   = (state == IDLE) && !rst;
  assign wdata_ready = (state == FILL);
  assign busy        = (state != IDLE);

  assign accept    = req_valid && req_ready;
  assign wbeat     = wdata_valid && wdata_ready;
  assign last_beat = (cnt == lat_len - LEN_W'(1));

`ifdef BURST_SRAM_MASTER_BOUND_CHECK_EN
  assign reject = exceeds_depth(req_addr, req_len);
`else
  assign reject = 1'b0;
`endif

  // The same counter indexes the buffer while filling and while bursting.
  burst_wbuf u_wbuf (
    .clk     (clk),
    .wr_en   (wbeat),
    .wr_addr (cnt),
    .wr_data (wdata),
    .rd_addr (cnt),
    .rd_data (buf_rd)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and SRAM bus drive; the bus is only non-zero in START and BURST.
  always_comb begin
    state_nxt      = state;
    sram_cs        = 1'b0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_burst_len = '0;
    sram_data_in   = '0;
    issue          = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && (req_len != '0) && !reject) begin
          state_nxt = req_we ? FILL : START;
        end
      end
      FILL: begin
        if (wdata_valid && last_beat) begin
          state_nxt = START;
        end
      end
      START: begin
        sram_cs        = 1'b1;
        sram_we        = lat_we;
        sram_addr      = lat_addr;
        sram_burst_len = lat_len;
        state_nxt      = BURST;
      end
      BURST: begin
        sram_cs        = 1'b1;
        sram_we        = lat_we;
        sram_addr      = lat_addr;
        sram_burst_len = lat_len;
        if (lat_we) begin
          sram_data_in = buf_rd;
        end else begin
          issue = 1'b1;
        end
        if (last_beat) begin
          state_nxt = (!lat_we && (RD_LAT > 1)) ? DRAIN : TURN;
        end
      end
      DRAIN: begin
        if (cnt == LEN_W'(RD_LAT - 2)) begin
          state_nxt = TURN;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, beat counter and the done/err one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_len  <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        lat_we   <= req_we;
        lat_addr <= req_addr;
        lat_len  <= req_len;
        if (reject) begin
          err <= 1'b1;
        end else if (req_len == '0) begin
          done <= 1'b1;
        end
      end
      if (state == TURN) begin
        done <= 1'b1;
      end
      case (state)
        IDLE:    cnt <= '0;
        FILL:    if (wbeat) cnt <= last_beat ? '0 : cnt + LEN_W'(1);
        BURST:   cnt <= last_beat ? '0 : cnt + LEN_W'(1);
        DRAIN:   cnt <= cnt + LEN_W'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // A read beat issued in BURST is sampled RD_LAT edges after it starts; the
  // extra stage only matters for RD_LAT=2.
  assign tap_valid = (RD_LAT == 1) ? issue : pend_valid;
  assign tap_last  = (RD_LAT == 1) ? (issue && last_beat) : pend_last;

  // Read-return pipeline and registered beat stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_last   <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      rdata       <= '0;
    end else begin
      pend_valid  <= issue;
      pend_last   <= issue && last_beat;
      rdata_valid <= tap_valid;
      rdata_last  <= tap_last;
      rdata       <= tap_valid ? sram_data_out : '0;
    end
  end

endmodule

// File: tb/tb_burst_sram_master.sv
// tb/tb_burst_sram_master.sv - scoreboard bench with SRAM bus model and reference memory
module tb_burst_sram_master;

  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr, req_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_last, done, err, busy;
  logic [7:0] rdata;
  logic       sram_cs, sram_we;
  logic [3:0] sram_addr, sram_burst_len;
  logic [7:0] sram_data_in, sram_data_out;

  burst_sram_master #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .done(done), .err(err), .busy(busy),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_burst_len(sram_burst_len), .sram_data_in(sram_data_in),
    .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } rd_exp_t;

  rd_exp_t    exp_rd[$];
  int         exp_done[$];
  int         exp_err[$];
  logic [7:0] ref_mem [16];
  logic [7:0] sram_mem [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err, busy,
            sram_cs, sram_we, sram_addr, sram_burst_len, sram_data_in};
  endfunction

  // SRAM bus model: counts cs cycles, stores write beats, returns read beats RD_LAT edges late.
  logic       bm_active = 1'b0;
  logic       bm_we;
  logic [3:0] bm_base, bm_len;
  int         bm_n;
  logic [7:0] cur, rd_prev;

  always @(negedge clk) begin
    cur = 8'h00;
    if (rst) begin
      bm_active = 1'b0;
      rd_prev   = 8'h00;
    end else if (sram_cs) begin
      if (!bm_active) begin
        bm_active = 1'b1;
        bm_n      = 0;
        bm_we     = sram_we;
        bm_base   = sram_addr;
        bm_len    = sram_burst_len;
      end else begin
        check("bus_hold", {sram_we, sram_addr, sram_burst_len}, {bm_we, bm_base, bm_len});
        if (bm_we) sram_mem[4'(int'(bm_base) + bm_n - 1)] = sram_data_in;
        else       cur = sram_mem[4'(int'(bm_base) + bm_n - 1)];
      end
      bm_n++;
    end else if (bm_active) begin
      bm_active = 1'b0;
      check("cs_cycles", bm_n, int'(bm_len) + 1);
    end
    if (RD_LAT == 1) begin
      sram_data_out = cur;
    end else begin
      sram_data_out = rd_prev;
      rd_prev       = cur;
    end
  end

  // Monitor: every rdata/done/err event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdata_valid) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_rdata", 1, 0);
        end else begin
          rd_exp_t e;
          e = exp_rd.pop_front();
          check("rdata", rdata, e.data);
          check("rdata_last", rdata_last, e.last);
          check("rdata_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          int c;
          c = exp_done.pop_front();
          if (c >= 0) check("done_cycle", cyc, c);
        end
      end
      if (err) begin
        if (exp_err.size() == 0) check("unexpected_err", 1, 0);
        else                     check("err_cycle", cyc, exp_err.pop_front());
      end
    end
  end

  task automatic send_req(input logic we, input logic [3:0] addr, input logic [3:0] len,
                          output int acc, output logic ok);
    int t;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = req_ready;
    if (!ok) check("req_ready_timeout", 0, 1);
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [3:0] addr, input logic [3:0] len,
                         input int gap, input logic [7:0] base);
    int   acc, t;
    logic ok, rej;
    logic [7:0] d;
    send_req(we, addr, len, acc, ok);
    if (!ok) return;
`ifdef BURST_SRAM_MASTER_BOUND_CHECK_EN
    rej = (int'(addr) + int'(len)) > 16;
`else
    rej = 1'b0;
`endif
    if (rej) begin
      exp_err.push_back(acc);
    end else if (len == 0) begin
      exp_done.push_back(acc);
    end else if (we) begin
      exp_done.push_back(gap == 0 ? acc + 2 * int'(len) + 2 : -1);
      for (int i = 0; i < int'(len); i++) begin
        wdata_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        d = base + 8'(i);
        wdata_valid = 1'b1;
        wdata = d;
        t = 0;
        @(negedge clk);
        while (!wdata_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (!wdata_ready) check("wdata_ready_timeout", 0, 1);
        @(posedge clk); #1;
        ref_mem[4'(int'(addr) + i)] = d;
      end
      wdata_valid = 1'b0;
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        exp_rd.push_back('{ref_mem[4'(int'(addr) + i)], (i == int'(len) - 1), acc + 1 + RD_LAT + i});
      end
      exp_done.push_back(acc + int'(len) + 1 + RD_LAT);
    end
    if (rej || len == 0) begin
      @(negedge clk);
      check("no_access", {busy, sram_cs, wdata_ready}, 3'b000);
    end
    t = 0;
    while ((exp_rd.size() != 0 || exp_done.size() != 0 || exp_err.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      check("completion_timeout", 0, 1);
      exp_rd.delete(); exp_done.delete(); exp_err.delete();
    end
  endtask

  initial begin
    int   acc;
    logic ok;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = 8'h00;
      sram_mem[i] = 8'h00;
    end
    sram_data_out = 8'h00;
    rd_prev = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 4'd0; req_len = 4'd0;
    wdata_valid = 1'b0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
    @(posedge clk); #1;

    run_req(1'b1, 4'd2, 4'd4, 0, 8'hA0);
    run_req(1'b0, 4'd2, 4'd4, 0, 8'h00);
    run_req(1'b1, 4'd10, 4'd1, 0, 8'hC2);
    run_req(1'b0, 4'd10, 4'd1, 0, 8'h00);
    run_req(1'b0, 4'd3, 4'd0, 0, 8'h00);
    run_req(1'b1, 4'd5, 4'd0, 0, 8'h00);
    run_req(1'b1, 4'd14, 4'd4, 0, 8'hD0);
    run_req(1'b0, 4'd0, 4'd2, 0, 8'h00);
    run_req(1'b1, 4'd9, 4'd6, 2, 8'hE0);
    run_req(1'b0, 4'd9, 4'd6, 0, 8'h00);

    send_req(1'b0, 4'd0, 4'd5, acc, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("reset_mid_burst", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_reset_quiet", {rdata_valid, done, busy, sram_cs}, 4'b0000);
    end
    @(posedge clk); #1;
    run_req(1'b0, 4'd2, 4'd4, 0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      run_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), 8'($urandom));
    end
    run_req(1'b0, 4'd0, 4'd15, 0, 8'h00);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/burst_sram_master.md
# burst_sram_master

Initiator-side controller for the 16×8 burst-mode SRAM. Accepts read/write burst requests on a valid/ready command port and stages write data in a local buffer. It then drives the SRAM burst protocol (cs/we/addr/burst_len/data_in) and returns read data as a beat stream with a last marker. It sits between any client block and the SRAM, so clients never sequence cs/we by hand.

## Interface
- RD_LAT, 1, cycles from a read beat's clock edge to the edge on which sram_data_out is sampled (legal 1..2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write burst, 0 = read burst
- req_addr  in  4  start address
- req_len  in  4  beat count (0..15)
- wdata_valid / wdata_ready  in / out  1 / 1  write-data handshake
- wdata  in  8  write beat payload
- rdata_valid  out  1  read beat strobe (no backpressure)
- rdata  out  8  read beat payload
- rdata_last  out  1  final read beat of burst
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse on rejected request (always 0 without macro)
- busy  out  1  high whenever state ≠ IDLE
- sram_cs, sram_we  out  1 each  SRAM chip select / write enable
- sram_addr, sram_burst_len  out  4 each  SRAM burst start address / length
- sram_data_in  out  8  SRAM write data
- sram_data_out  in  8  SRAM read data

## Operation
- States: IDLE, FILL, START, BURST, DRAIN, TURN.
- IDLE: req_ready=1. On accept, latch we/addr/len. If len=0, pulse done next cycle and stay IDLE; no SRAM access. Otherwise go to FILL for writes and START for reads.
- FILL: wdata_ready=1. Accept exactly len beats into buffer entries 0..len-1, with gaps allowed. Extra wdata is not accepted: wdata_ready=0 outside FILL.
- START (1 cycle): sram_cs=1, sram_we=we, sram_addr=addr, sram_burst_len=len.
- BURST (len cycles, beat counter k=0..len-1): cs and we held, and addr/burst_len held at their start values.
  - Write: sram_data_in = buffer[k].
  - Read: beat k's data is sampled RD_LAT edges after beat k's edge.
- DRAIN (read only, RD_LAT−1 cycles, cs=0): collects outstanding beats.
- TURN (1 cycle, cs=0, we=0): bus turnaround. done pulses on exiting TURN, then return to IDLE.
- Read output: rdata_valid pulses once per sampled beat, in address order. rdata_last coincides with beat len-1. Exactly len beats are returned per burst.
- Address arithmetic is mod 16: a burst from 14 of length 4 touches 14, 15, 0, 1 (wrap), unless the macro below rejects it.
- Reset (any time, including mid-burst): all outputs go to 0 immediately, state goes to IDLE, counters clear, buffer contents are don't-care, and no done is issued for the aborted burst.

## Timing
- Reset values: req_ready=0 while rst is high, then 1 in IDLE. All other outputs 0.
- Read, len=N, RD_LAT=L:
  - Request accepted at edge 0; START occupies cycle 1; BURST occupies cycles 2..N+1.
  - First rdata_valid at cycle 2+L; last at N+1+L.
  - done at the cycle after TURN.
- Write, len=N, wdata streamed back-to-back: FILL takes N cycles, then START (1), BURST (N), TURN (1), then done.
- Request accepted only in IDLE. Back-to-back requests incur a minimum of one idle cycle.

## Configuration
- BURST_SRAM_MASTER_BOUND_CHECK_EN defined:
  - A request with addr+len > 16 is accepted, then rejected: err pulses one cycle after accept.
  - No FILL, no SRAM activity, no done.
- Macro undefined: err is tied 0 and wrapping bursts execute mod 16.

## Structure
- Package burst_sram_pkg:
  - ADDR_W=4, LEN_W=4, DATA_W=8, DEPTH=16.
  - State enum bsm_state_t.
- Sub-module burst_wbuf: 16×8 register-file write staging buffer, with write port from FILL and read port indexed by the beat counter.

## Test plan
- Write addr=2, len=4, wdata A0,A1,A2,A3; then read addr=2, len=4 → rdata A0..A3 with rdata_last on A3; done once per burst.
- Write addr=10, len=1, C2; read back → single beat C2 with rdata_valid and rdata_last together; sram_cs high for exactly 2 cycles.
- Request len=0 → done next cycle, sram_cs never asserted, busy never high.
- Write addr=14, len=4 (D0..D3); read addr=0, len=2 → D2,D3 without macro. With macro, the write is rejected: err pulses and there is no SRAM access.
- Write addr=9, len=6 with wdata_valid gapped (1 beat every 3 cycles) → FILL waits; BURST drives E-values contiguously for 6 cycles.
- Assert rst during BURST of a read addr=0, len=5 → all outputs 0 the same cycle, no further rdata_valid or done; a following request completes normally.
